dnn_result_uart_tx: RTL and testbench

UART transmitter that returns DNN inference results to the host over the board's serial line (UART_RXD_OUT at the top level). It is the outbound counterpart of the host-to-board UART path that loads inputs. On a start request it latches a packed result word and sends it as an 8N1 frame: one header byte followed by NUM_BYTES payload bytes. Top-level instantiation is in DNN_top: start comes from the run-finished pulse or the BTND press, and done drives the transmission-complete LED logic.

---
 rtl/dnn_uart_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 105 ++++++++++
 rtl/dnn_result_uart_tx.sv | 91 +++++++++
 tb/tb_dnn_result_uart_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_uart_pkg.sv
// Shared definitions for the DNN board UART paths: bit-level state encoding,
// default framing byte and the baud divisor calculation.
package dnn_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Rounded to the nearest integer so odd clock/baud ratios keep minimal drift.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A load accepted in the last stop-bit cycle chains
// straight into the next start bit, so multi-byte packets have no idle gaps.
module uart_tx_byte
    import dnn_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_e      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             tx_q, tx_n;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);
    assign ready   = (state == IDLE) || ((state == STOP) && bit_end);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx_q    <= tx_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx_q;
        case (state)
            IDLE: begin
                if (load) begin
                    state_n = START;
                    cnt_n   = '0;
                    shift_n = byte_in;
                    tx_n    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                    shift_n   = {1'b0, shift[7:1]};
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = shift[0];
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (load) begin
                        state_n = START;
                        shift_n = byte_in;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/dnn_result_uart_tx.sv
// Sends a latched DNN result word to the host as one header byte followed by
// NUM_BYTES payload bytes (byte 0 first), reusing uart_tx_byte for framing.
module dnn_result_uart_tx
    import dnn_uart_pkg::*;
#(
    parameter int         CLK_FREQ  = 100_000_000,
    parameter int         BAUD_RATE = 115_200,
    parameter int         NUM_BYTES = 4,
    parameter logic [7:0] HEADER    = HEADER_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] data,
    output logic                   uart_tx,
    output logic                   busy,
    output logic                   done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IDX_W        = $clog2(NUM_BYTES + 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("dnn_result_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
        $error("dnn_result_uart_tx: NUM_BYTES must be in 1..16");
    end

    logic [8*NUM_BYTES-1:0] payload;
    logic [IDX_W-1:0]       byte_idx;
    logic [7:0]             byte_val;
    logic                   byte_ready;
    logic                   byte_load;
    logic                   accept;
    logic                   more;
    logic                   last;

    // While busy, byte_ready only rises in the final stop-bit cycle of a byte.
    assign accept    = start && !busy && byte_ready;
    assign more      = busy && byte_ready && (byte_idx != IDX_W'(NUM_BYTES));
    assign last      = busy && byte_ready && (byte_idx == IDX_W'(NUM_BYTES));
    assign byte_load = accept || more;

    always_comb begin
        byte_val = HEADER;
        if (busy) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (byte_idx == IDX_W'(k)) begin
                    byte_val = payload[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= '0;
        end else begin
            done <= last;
            if (accept) begin
                busy     <= 1'b1;
                byte_idx <= '0;
            end else if (more) begin
                byte_idx <= byte_idx + 1'b1;
            end else if (last) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            payload <= data;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk    (clk),
        .rst_n  (reset),
        .load   (byte_load),
        .byte_in(byte_val),
        .ready  (byte_ready),
        .tx     (uart_tx)
    );

endmodule

// File: tb/tb_dnn_result_uart_tx.sv
// Directed bench for dnn_result_uart_tx at 10 clocks per bit, 2 payload bytes.
module tb_dnn_result_uart_tx;

    localparam int MAXC = 700;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        uart_tx;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    logic obs_tx   [0:MAXC];
    logic obs_busy [0:MAXC];
    logic obs_done [0:MAXC];

    logic [7:0] mon_byte[$];
    bit         mon_fok[$];

    always #5 clk = ~clk;

    dnn_result_uart_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD_RATE(100_000),
        .NUM_BYTES(2),
        .HEADER   (8'hA5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data   (data),
        .uart_tx(uart_tx),
        .busy   (busy),
        .done   (done)
    );

    // Line monitor: samples each bit in its middle (5th of 10 cycles).
    initial begin : monitor
        bit         active;
        int         cnt;
        bit         ok;
        logic [7:0] sh;
        logic       prev;
        active = 0; cnt = 0; ok = 0; sh = '0; prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                active = 0;
            end else if (!active) begin
                if (prev === 1'b1 && uart_tx === 1'b0) begin
                    active = 1; cnt = 0; ok = 1; sh = '0;
                end
            end else begin
                cnt++;
                if (cnt == 4) begin
                    ok = ok && (uart_tx === 1'b0);
                end else if (cnt >= 14 && cnt <= 84 && (cnt - 4) % 10 == 0) begin
                    sh[(cnt - 14) / 10] = uart_tx;
                end else if (cnt == 94) begin
                    ok = ok && (uart_tx === 1'b1);
                    mon_byte.push_back(sh);
                    mon_fok.push_back(ok);
                    active = 0;
                end
            end
            prev = uart_tx;
        end
    end

    // Reference line level for cycle k of a 3-byte packet (k = 0 is the first start-bit cycle).
    function automatic logic exp_bit(input logic [23:0] fb, input int k);
        int p, b, f;
        if (k >= 300) return 1'b1;
        p = k / 10; b = p / 10; f = p % 10;
        if (f == 0) return 1'b0;
        if (f == 9) return 1'b1;
        return fb[b*8 + f - 1];
    endfunction

    function automatic int wave_errs(input logic [23:0] fb, input int from, input int to);
        int e = 0;
        for (int n = from; n <= to; n++)
            if (obs_tx[n] !== exp_bit(fb, n - from)) e++;
        return e;
    endfunction

    function automatic int count_busy(input int from, input int to);
        int c = 0;
        for (int n = from; n <= to; n++) if (obs_busy[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done(input int from, input int to);
        int c = 0;
        for (int n = from; n <= to; n++) if (obs_done[n] === 1'b1) c++;
        return c;
    endfunction

    // Start pulse in cycle 0, then record outputs for cycles 1..ncyc.
    // ev_kind: 0 none, 1 start pulse with ev_data, 2 change data, 3 reset low for 5 cycles.
    task automatic run_packet(input logic [15:0] d, input int ncyc, input int ev_cycle,
                              input int ev_kind, input logic [15:0] ev_data);
        @(posedge clk); #1;
        data = d; start = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (ev_kind == 1 && n == ev_cycle) begin start = 1'b1; data = ev_data; end
            if (ev_kind == 2 && n == ev_cycle) data = ev_data;
            if (ev_kind == 3 && n == ev_cycle) reset = 1'b0;
            if (ev_kind == 3 && n == ev_cycle + 5) reset = 1'b1;
            @(negedge clk);
            obs_tx[n] = uart_tx; obs_busy[n] = busy; obs_done[n] = done;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (uart_tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b want 1", uart_tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        @(posedge clk); #1; reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_after_reset got tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        int e;
        exp_b = '{8'hA5, 8'h81, 8'h3C};
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h3C81, 320, 0, 0, 16'h0000);
        vectors++; if (obs_tx[1] !== 1'b0) begin miscompares++; $display("FAIL start_latency tx[1] got %b want 0", obs_tx[1]); end
        e = wave_errs({16'h3C81, 8'hA5}, 1, 320);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL basic_bit_timing got %0d bad cycles want 0", e); end
        e = count_busy(1, 320);
        vectors++; if (e != 300) begin miscompares++; $display("FAIL basic_busy_len got %0d want 300", e); end
        vectors++; if (obs_busy[1] !== 1'b1 || obs_busy[301] !== 1'b0) begin
            miscompares++; $display("FAIL basic_busy_edges got %b/%b want 1/0", obs_busy[1], obs_busy[301]);
        end
        e = count_done(1, 320);
        vectors++; if (e != 1 || obs_done[301] !== 1'b1) begin
            miscompares++; $display("FAIL basic_done got count=%0d done[301]=%b want 1/1", e, obs_done[301]);
        end
        vectors++; if (mon_byte.size() != 3) begin miscompares++; $display("FAIL basic_nbytes got %0d want 3", mon_byte.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= mon_byte.size()) begin miscompares++; $display("FAIL basic_byte%0d missing want %h", i, exp_b[i]); end
            else if (mon_byte[i] !== exp_b[i] || !mon_fok[i]) begin
                miscompares++; $display("FAIL basic_byte%0d got %h frame_ok=%0d want %h", i, mon_byte[i], mon_fok[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int e;
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h3C81, 340, 50, 1, 16'hFFFF);
        e = wave_errs({16'h3C81, 8'hA5}, 1, 340);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL busy_start_wave got %0d bad cycles want 0", e); end
        e = count_done(1, 340);
        vectors++; if (e != 1) begin miscompares++; $display("FAIL busy_start_done got %0d want 1", e); end
        vectors++;
        if (mon_byte.size() != 3) begin miscompares++; $display("FAIL busy_start_bytes got %0d bytes want 3", mon_byte.size()); end
        else if (mon_byte[0] !== 8'hA5 || mon_byte[1] !== 8'h81 || mon_byte[2] !== 8'h3C) begin
            miscompares++; $display("FAIL busy_start_bytes got %h %h %h want a5 81 3c", mon_byte[0], mon_byte[1], mon_byte[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [6];
        int e;
        exp_b = '{8'hA5, 8'h81, 8'h3C, 8'hA5, 8'h02, 8'h01};
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h3C81, 620, 301, 1, 16'h0102);
        vectors++; if (obs_tx[301] !== 1'b1 || obs_done[301] !== 1'b1 || obs_busy[301] !== 1'b0) begin
            miscompares++; $display("FAIL b2b_gap_cycle got tx=%b done=%b busy=%b want 1/1/0", obs_tx[301], obs_done[301], obs_busy[301]);
        end
        vectors++; if (obs_tx[302] !== 1'b0) begin miscompares++; $display("FAIL b2b_second_start got %b want 0", obs_tx[302]); end
        e = wave_errs({16'h3C81, 8'hA5}, 1, 300) + wave_errs({16'h0102, 8'hA5}, 302, 620);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL b2b_wave got %0d bad cycles want 0", e); end
        e = count_busy(1, 620);
        vectors++; if (e != 600) begin miscompares++; $display("FAIL b2b_busy_len got %0d want 600", e); end
        e = count_done(1, 620);
        vectors++; if (e != 2 || obs_done[602] !== 1'b1) begin
            miscompares++; $display("FAIL b2b_done got count=%0d done[602]=%b want 2/1", e, obs_done[602]);
        end
        vectors++; if (mon_byte.size() != 6) begin miscompares++; $display("FAIL b2b_nbytes got %0d want 6", mon_byte.size()); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= mon_byte.size()) begin miscompares++; $display("FAIL b2b_byte%0d missing want %h", i, exp_b[i]); end
            else if (mon_byte[i] !== exp_b[i] || !mon_fok[i]) begin
                miscompares++; $display("FAIL b2b_byte%0d got %h frame_ok=%0d want %h", i, mon_byte[i], mon_fok[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int e;
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h3C81, 140, 125, 3, 16'h0000);
        vectors++; if (obs_tx[124] !== 1'b0) begin miscompares++; $display("FAIL rst_pre_tx got %b want 0", obs_tx[124]); end
        vectors++; if (obs_tx[125] !== 1'b1 || obs_busy[125] !== 1'b0) begin
            miscompares++; $display("FAIL rst_immediate got tx=%b busy=%b want 1/0", obs_tx[125], obs_busy[125]);
        end
        e = count_done(1, 140);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL rst_no_done got %0d want 0", e); end
        e = 0;
        for (int n = 125; n <= 140; n++) if (obs_tx[n] !== 1'b1) e++;
        vectors++; if (e != 0) begin miscompares++; $display("FAIL rst_line_high got %0d low cycles want 0", e); end
        vectors++; if (mon_byte.size() != 1) begin miscompares++; $display("FAIL rst_partial_bytes got %0d want 1", mon_byte.size()); end
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h5500, 310, 0, 0, 16'h0000);
        e = wave_errs({16'h5500, 8'hA5}, 1, 310);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL rst_recover_wave got %0d bad cycles want 0", e); end
        vectors++;
        if (mon_byte.size() != 3) begin miscompares++; $display("FAIL rst_recover_bytes got %0d bytes want 3", mon_byte.size()); end
        else if (mon_byte[0] !== 8'hA5 || mon_byte[1] !== 8'h00 || mon_byte[2] !== 8'h55) begin
            miscompares++; $display("FAIL rst_recover_bytes got %h %h %h want a5 00 55", mon_byte[0], mon_byte[1], mon_byte[2]);
        end
        e = count_done(1, 310);
        vectors++; if (e != 1 || obs_done[301] !== 1'b1) begin
            miscompares++; $display("FAIL rst_recover_done got count=%0d done[301]=%b want 1/1", e, obs_done[301]);
        end
    endtask

    task automatic test_data_change();
        int e;
        mon_byte.delete(); mon_fok.delete();
        run_packet(16'h3C81, 310, 20, 2, 16'h0000);
        e = wave_errs({16'h3C81, 8'hA5}, 1, 310);
        vectors++; if (e != 0) begin miscompares++; $display("FAIL data_change_wave got %0d bad cycles want 0", e); end
        vectors++;
        if (mon_byte.size() != 3) begin miscompares++; $display("FAIL data_change_bytes got %0d bytes want 3", mon_byte.size()); end
        else if (mon_byte[0] !== 8'hA5 || mon_byte[1] !== 8'h81 || mon_byte[2] !== 8'h3C) begin
            miscompares++; $display("FAIL data_change_bytes got %h %h %h want a5 81 3c", mon_byte[0], mon_byte[1], mon_byte[2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midframe();
        test_data_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
